mem_access_stage: RTL

Memory-access stage of the 6-stage core. It sits directly downstream of the execute-stage ALU result register. It consumes the registered ALU result as either a load/store address or a pass-through value, and runs a request/grant/response handshake with data memory. It performs store byte-lane steering and load sign/zero extension, and produces a registered writeback bundle. It stalls upstream while an access is outstanding.

---
 rtl/mem_access_stage_if.sv | 28 ++
 rtl/mem_access_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory request/grant/response bus between the memory-access stage
// (master) and data memory (slave).
//   dmem_req/dmem_we/dmem_addr/dmem_wdata/dmem_be : request side, master -> slave
//   dmem_gnt                                      : request accepted, slave -> master
//   dmem_rvalid/dmem_rdata                        : load response, slave -> master
interface mem_access_stage_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [BE_W-1:0] dmem_be;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage: turns the registered ALU result into a data-memory
// load/store (or passes it through), steers store lanes, extends load data and
// produces a registered writeback bundle. Stalls upstream while an access is
// outstanding; an access that exceeds TIMEOUT cycles retires with bus_err_out.
//   clk, n_rst          : clock, async active-low reset
//   valid_in .. flush_in: instruction from execute
//   stall_out           : combinational upstream hold
//   dmem                : data-memory bus (master side)
//   valid_out .. bus_err_out : registered writeback bundle
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              valid_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [2:0]        funct3_in,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       wdata_in,
  input  logic [4:0]        rd_in,
  input  logic              reg_write_in,
  input  logic              flush_in,
  output logic              stall_out,
  mem_access_stage_if.master dmem,
  output logic              valid_out,
  output logic [31:0]       result_out,
  output logic [4:0]        rd_out,
  output logic              reg_write_out,
  output logic              misalign_out,
  output logic              bus_err_out
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;
  // Counter value of the last allowed cycle: the increment at this edge would reach TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [4:0]        rd_q, rd_d;
  logic              rw_q, rw_d;

  logic              valid_d, mis_d, berr_d, rw_out_d, req_d, we_d;
  logic [XLEN-1:0]   result_d, addr_d, wdata_d;
  logic [4:0]        rd_out_d;
  logic [3:0]        be_d;

  logic              is_mem, illegal, misaligned, tmo;
  logic [3:0]        st_be;
  logic [XLEN-1:0]   st_wdata, ld_data;

  // Load lane extraction and sign/zero extension.
  function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                   input logic [XLEN-1:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b100:  load_extract = {24'd0, b};
      3'b101:  load_extract = {16'd0, h};
      default: load_extract = d;
    endcase
  endfunction

  // Input classification; funct3[1:0] encodes the access width.
  assign is_mem     = mem_read_in | mem_write_in;
  assign illegal    = (funct3_in == 3'b011) || (funct3_in == 3'b110) || (funct3_in == 3'b111);
  assign misaligned = ((funct3_in[1:0] == 2'b01) && addr_in[0]) ||
                      ((funct3_in[1:0] == 2'b10) && (addr_in[1:0] != 2'b00));
  assign tmo        = (cnt_q == CNT_LAST);
  assign ld_data    = load_extract(f3_q, off_q, dmem.dmem_rdata);

  // Store byte-lane steering.
  always_comb begin
    case (funct3_in[1:0])
      2'b00: begin
        st_be    = 4'(4'b0001 << addr_in[1:0]);
        st_wdata = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        st_be    = addr_in[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata_in[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = wdata_in;
      end
    endcase
  end

  // Next state, stall and next values of all registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_store_d = is_store_q;
    f3_d       = f3_q;
    off_d      = off_q;
    rd_d       = rd_q;
    rw_d       = rw_q;
    valid_d    = 1'b0;
    mis_d      = 1'b0;
    berr_d     = 1'b0;
    rw_out_d   = 1'b0;
    result_d   = result_out;
    rd_out_d   = rd_out;
    req_d      = 1'b0;
    we_d       = 1'b0;
    addr_d     = dmem.dmem_addr;
    wdata_d    = dmem.dmem_wdata;
    be_d       = dmem.dmem_be;
    stall_out  = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_in && !flush_in) begin
          if (!is_mem) begin
            valid_d  = 1'b1;
            result_d = addr_in;
            rd_out_d = rd_in;
            rw_out_d = reg_write_in;
          end else if (illegal || misaligned) begin
            valid_d  = 1'b1;
            mis_d    = 1'b1;
            rd_out_d = rd_in;
          end else begin
            stall_out  = 1'b1;
            state_d    = REQ;
            cnt_d      = '0;
            is_store_d = mem_write_in;
            f3_d       = funct3_in;
            off_d      = addr_in[1:0];
            rd_d       = rd_in;
            rw_d       = reg_write_in;
            req_d      = 1'b1;
            we_d       = mem_write_in;
            addr_d     = {addr_in[31:2], 2'b00};
            be_d       = mem_write_in ? st_be : 4'b1111;
            wdata_d    = mem_write_in ? st_wdata : '0;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (dmem.dmem_gnt && is_store_q) begin
          state_d  = IDLE;
          valid_d  = 1'b1;
          rd_out_d = rd_q;
        end else if (tmo) begin
          state_d  = IDLE;
          valid_d  = 1'b1;
          berr_d   = 1'b1;
          rd_out_d = rd_q;
        end else if (dmem.dmem_gnt) begin
          stall_out = 1'b1;
          state_d   = WAIT;
        end else begin
          stall_out = 1'b1;
          req_d     = 1'b1;
          we_d      = is_store_q;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (dmem.dmem_rvalid) begin
          state_d  = IDLE;
          valid_d  = 1'b1;
          result_d = ld_data;
          rd_out_d = rd_q;
          rw_out_d = rw_q;
        end else if (tmo) begin
          state_d  = IDLE;
          valid_d  = 1'b1;
          berr_d   = 1'b1;
          rd_out_d = rd_q;
        end else begin
          stall_out = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured instruction and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      is_store_q      <= 1'b0;
      f3_q            <= '0;
      off_q           <= '0;
      rd_q            <= '0;
      rw_q            <= 1'b0;
      valid_out       <= 1'b0;
      result_out      <= '0;
      rd_out          <= '0;
      reg_write_out   <= 1'b0;
      misalign_out    <= 1'b0;
      bus_err_out     <= 1'b0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      dmem.dmem_be    <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      is_store_q      <= is_store_d;
      f3_q            <= f3_d;
      off_q           <= off_d;
      rd_q            <= rd_d;
      rw_q            <= rw_d;
      valid_out       <= valid_d;
      result_out      <= result_d;
      rd_out          <= rd_out_d;
      reg_write_out   <= rw_out_d;
      misalign_out    <= mis_d;
      bus_err_out     <= berr_d;
      dmem.dmem_req   <= req_d;
      dmem.dmem_we    <= we_d;
      dmem.dmem_addr  <= addr_d;
      dmem.dmem_wdata <= wdata_d;
      dmem.dmem_be    <= be_d;
    end
  end
endmodule
